// File: rtl/lsu_trigger_ctl_pkg.sv
// ---------------------------------------------------------------------------
// lsu_trigger_ctl_pkg
// Shared types for the LSU trigger sequencing logic.
//   - NUM_TRIG_DEF      : default trigger count (must be even, pairs (0,1),(2,3)...)
//   - trig_action_e     : tdata1.action encoding (DBG = enter debug, EXC = breakpoint)
//   - lsu_trig_state_e  : debug-halt request FSM states
// ---------------------------------------------------------------------------
package lsu_trigger_ctl_pkg;

  localparam int NUM_TRIG_DEF = 4;

  typedef enum logic {
    EXC = 1'b0,
    DBG = 1'b1
  } trig_action_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_trig_state_e;

endpackage

// File: rtl/lsu_trigger_ctl_chain.sv
// ---------------------------------------------------------------------------
// lsu_trigger_chain
// Combinational chained-pair resolution for trigger hits. For each pair
// (2k, 2k+1), when chain[2k] is set both triggers fire only if both hit;
// otherwise each trigger fires on its own hit. Odd chain bits carry no meaning.
// Ports:
//   i_hit   [NUM_TRIG] : per-trigger hit (already enable-qualified)
//   i_chain [NUM_TRIG] : tdata1.chain per trigger (even indices used)
//   o_fire  [NUM_TRIG] : resolved per-trigger fire
// ---------------------------------------------------------------------------
module lsu_trigger_chain
  import lsu_trigger_ctl_pkg::*;
#(
  parameter int NUM_TRIG = NUM_TRIG_DEF
) (
  input  logic [NUM_TRIG-1:0] i_hit,
  input  logic [NUM_TRIG-1:0] i_chain,
  output logic [NUM_TRIG-1:0] o_fire
);

  localparam int NUM_PAIR = NUM_TRIG / 2;

  logic [NUM_PAIR-1:0] w_pair_both;
  logic [NUM_PAIR-1:0] w_chain_odd;
  logic                w_unused_chain_odd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAIR; gi++) begin : g_pair
      assign w_pair_both[gi]  = i_hit[2*gi] & i_hit[2*gi+1];
      assign o_fire[2*gi]     = i_chain[2*gi] ? w_pair_both[gi] : i_hit[2*gi];
      assign o_fire[2*gi+1]   = i_chain[2*gi] ? w_pair_both[gi] : i_hit[2*gi+1];
      assign w_chain_odd[gi]  = i_chain[2*gi+1];
    end
  endgenerate

  // Odd chain bits are architecturally ignored here.
  assign w_unused_chain_odd = ^w_chain_odd;

endmodule

// File: rtl/lsu_trigger_ctl.sv
// ---------------------------------------------------------------------------
// lsu_trigger_ctl
// Turns raw DC3 LSU trigger matches into architectural trigger events:
// stages them through DC4/DC5, resolves chained pairs, drops flushed
// accesses, keeps sticky hit bits, and raises either a held debug-halt
// request (handshaked with the debug unit) or a one-cycle breakpoint pulse.
// Ports:
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_lsu_trigger_match_dc3      : raw per-trigger match in DC3
//   i_trig_chain/action/enable   : per-trigger tdata1 configuration
//   i_lsu_flush_dc4/dc5          : kill the access currently in DC4/DC5
//   i_dbg_halt_ack               : debug unit accepted the halt request
//   i_hit_clr                    : write-1-to-clear for sticky hit bits
//   o_lsu_trigger_fire_dc5       : fired triggers for the DC5 access
//   o_lsu_trigger_exc_dc5        : one-cycle breakpoint exception request
//   o_lsu_dbg_halt_req           : held debug-halt request
//   o_trig_hit_sticky            : tdata1.hit status
// ---------------------------------------------------------------------------
module lsu_trigger_ctl
  import lsu_trigger_ctl_pkg::*;
#(
  parameter int NUM_TRIG = NUM_TRIG_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_TRIG-1:0] i_lsu_trigger_match_dc3,
  input  logic [NUM_TRIG-1:0] i_trig_chain,
  input  logic [NUM_TRIG-1:0] i_trig_action,
  input  logic [NUM_TRIG-1:0] i_trig_enable,
  input  logic                i_lsu_flush_dc4,
  input  logic                i_lsu_flush_dc5,
  input  logic                i_dbg_halt_ack,
  input  logic [NUM_TRIG-1:0] i_hit_clr,
  output logic [NUM_TRIG-1:0] o_lsu_trigger_fire_dc5,
  output logic                o_lsu_trigger_exc_dc5,
  output logic                o_lsu_dbg_halt_req,
  output logic [NUM_TRIG-1:0] o_trig_hit_sticky
);

  logic [NUM_TRIG-1:0] r_hit4;
  logic [NUM_TRIG-1:0] r_fire5;
  logic [NUM_TRIG-1:0] r_sticky;
  lsu_trig_state_e     r_state;
  lsu_trig_state_e     w_state_next;

  logic [NUM_TRIG-1:0] w_fire4;
  logic [NUM_TRIG-1:0] w_fire_dc5;
  logic [NUM_TRIG-1:0] w_is_dbg;
  logic                w_dbg_fire;
  logic                w_exc_any;

  lsu_trigger_chain #(
    .NUM_TRIG (NUM_TRIG)
  ) u_chain (
    .i_hit   (r_hit4),
    .i_chain (i_trig_chain),
    .o_fire  (w_fire4)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TRIG; gi++) begin : g_action
      assign w_is_dbg[gi] = (trig_action_e'(i_trig_action[gi]) == DBG);
    end
  endgenerate

  assign w_fire_dc5 = r_fire5 & ~{NUM_TRIG{i_lsu_flush_dc5}};
  assign w_dbg_fire = |(w_fire_dc5 & w_is_dbg);
  assign w_exc_any  = |(w_fire_dc5 & ~w_is_dbg);

  // The DC4 flush kills the access that is sitting in DC4 this cycle, so it
  // gates the DC4->DC5 transfer; the access arriving from DC3 is unaffected.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit4   <= '0;
      r_fire5  <= '0;
      r_sticky <= '0;
      r_state  <= ST_IDLE;
    end else begin
      r_hit4   <= i_lsu_trigger_match_dc3 & i_trig_enable;
      r_fire5  <= i_lsu_flush_dc4 ? '0 : w_fire4;
      // Set dominates a simultaneous clear.
      r_sticky <= (r_sticky & ~i_hit_clr) | w_fire_dc5;
      r_state  <= w_state_next;
    end
  end

  // Fires seen while a request is outstanding only land in the sticky bits.
  always_comb begin
    w_state_next          = r_state;
    o_lsu_dbg_halt_req    = 1'b0;
    o_lsu_trigger_exc_dc5 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_lsu_trigger_exc_dc5 = w_exc_any & ~w_dbg_fire;
        if (w_dbg_fire) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        o_lsu_dbg_halt_req = 1'b1;
        if (i_dbg_halt_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_lsu_trigger_fire_dc5 = w_fire_dc5;
  assign o_trig_hit_sticky      = r_sticky;

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
module tb_lsu_trigger_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] match, chain, action, enable, clr;
  logic       fl4, fl5, ack;
  logic [3:0] fire_o, sticky_o;
  logic       exc_o, halt_o;

  always #5 clk = ~clk;

  lsu_trigger_ctl #(.NUM_TRIG(4)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_lsu_trigger_match_dc3 (match),
    .i_trig_chain            (chain),
    .i_trig_action           (action),
    .i_trig_enable           (enable),
    .i_lsu_flush_dc4         (fl4),
    .i_lsu_flush_dc5         (fl5),
    .i_dbg_halt_ack          (ack),
    .i_hit_clr               (clr),
    .o_lsu_trigger_fire_dc5  (fire_o),
    .o_lsu_trigger_exc_dc5   (exc_o),
    .o_lsu_dbg_halt_req      (halt_o),
    .o_trig_hit_sticky       (sticky_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rst_cyc = -1;

  // Reference model: per-cycle input history plus architectural state.
  logic [3:0] m_h  [0:4095];
  logic [3:0] en_h [0:4095];
  logic [3:0] ch_h [0:4095];
  bit         f4_h [0:4095];
  bit         f5_h [0:4095];
  bit         halt_m;
  logic [3:0] sticky_m;
  logic [3:0] e_fire, e_sticky;
  bit         e_exc, e_halt;

  // A chained pair fires only when both members hit.
  function automatic logic [3:0] resolve(input logic [3:0] hits, input logic [3:0] ch);
    logic [3:0] r;
    r = hits;
    for (int p = 0; p < 2; p++) begin
      if (ch[2*p] && !(hits[2*p] && hits[2*p+1])) begin
        r[2*p]   = 1'b0;
        r[2*p+1] = 1'b0;
      end
    end
    return r;
  endfunction

  // Fire seen in cycle c belongs to the access issued in DC3 at c-2.
  function automatic logic [3:0] model_fire(input int c);
    if (c - 2 <= rst_cyc) return 4'b0000;
    if (f4_h[c-1] || f5_h[c]) return 4'b0000;
    return resolve(m_h[c-2] & en_h[c-2], ch_h[c-1]);
  endfunction

  task automatic drive(input logic [3:0] m, input bit f4, input bit f5,
                       input bit a, input logic [3:0] cl);
    bit dbg;
    match = m; fl4 = f4; fl5 = f5; ack = a; clr = cl;
    m_h[cyc] = m; en_h[cyc] = enable; ch_h[cyc] = chain;
    f4_h[cyc] = f4; f5_h[cyc] = f5;
    #1;
    e_fire   = model_fire(cyc);
    dbg      = |(e_fire & action);
    e_exc    = !halt_m && (|(e_fire & ~action)) && !dbg;
    e_halt   = halt_m;
    e_sticky = sticky_m;
  endtask

  task automatic adv();
    @(posedge clk);
    sticky_m = (sticky_m & ~clr) | e_fire;
    if (!halt_m) halt_m = |(e_fire & action);
    else if (ack) halt_m = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  // Drain the pipe, release any halt, wipe sticky bits.
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'hF);
      adv();
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (fire_o !== 4'b0000) $display("FAIL reset_fire got %b want 0000", fire_o); else n_pass++;
    n_total++; if (exc_o !== 1'b0) $display("FAIL reset_exc got %b want 0", exc_o); else n_pass++;
    n_total++; if (halt_o !== 1'b0) $display("FAIL reset_halt got %b want 0", halt_o); else n_pass++;
    n_total++; if (sticky_o !== 4'b0000) $display("FAIL reset_sticky got %b want 0000", sticky_o); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    $display("reset: released at cycle %0d", cyc);
  endtask

  task automatic test_single_exc();
    enable = 4'hF; chain = 4'h0; action = 4'h0;
    settle();
    for (int i = 0; i < 5; i++) begin
      drive((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0001) $display("FAIL single_fire got %b want 0001", fire_o); else n_pass++;
        n_total++; if (exc_o !== 1'b1) $display("FAIL single_exc got %b want 1", exc_o); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (sticky_o !== 4'b0001) $display("FAIL single_sticky got %b want 0001", sticky_o); else n_pass++;
        n_total++; if (exc_o !== 1'b0) $display("FAIL single_exc_width got %b want 0", exc_o); else n_pass++;
      end
      adv();
    end
    $display("single_exc: trigger 0 breakpoint sequence done");
  endtask

  task automatic test_chain();
    enable = 4'hF; chain = 4'b0001; action = 4'h0;
    settle();
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? 4'b0001 : (i == 2) ? 4'b0011 : 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0000) $display("FAIL chain_half got %b want 0000", fire_o); else n_pass++;
      end
      if (i == 4) begin
        n_total++; if (fire_o !== 4'b0011) $display("FAIL chain_both got %b want 0011", fire_o); else n_pass++;
      end
      adv();
    end
    chain = 4'h0;
    $display("chain: pair (0,1) resolution done");
  endtask

  task automatic test_flush();
    enable = 4'hF; chain = 4'h0; action = 4'h0;
    settle();
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 4'b0100 : 4'b0000, i == 1, 1'b0, 1'b0, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0000) $display("FAIL flush4_fire got %b want 0000", fire_o); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (sticky_o !== 4'b0000) $display("FAIL flush4_sticky got %b want 0000", sticky_o); else n_pass++;
      end
      adv();
    end
    settle();
    for (int i = 0; i < 4; i++) begin
      drive((i == 0) ? 4'b0100 : 4'b0000, 1'b0, i == 2, 1'b0, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0000) $display("FAIL flush5_fire got %b want 0000", fire_o); else n_pass++;
        n_total++; if (exc_o !== 1'b0) $display("FAIL flush5_exc got %b want 0", exc_o); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (sticky_o !== 4'b0000) $display("FAIL flush5_sticky got %b want 0000", sticky_o); else n_pass++;
      end
      adv();
    end
    settle();
    // Flush in DC4 hits only the older of two back-to-back accesses.
    for (int i = 0; i < 5; i++) begin
      drive((i < 2) ? 4'b0100 : 4'b0000, i == 1, 1'b0, 1'b0, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0000) $display("FAIL flush_b2b_old got %b want 0000", fire_o); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (fire_o !== 4'b0100) $display("FAIL flush_b2b_young got %b want 0100", fire_o); else n_pass++;
      end
      adv();
    end
    $display("flush: DC4/DC5 kill sequences done");
  endtask

  task automatic test_debug_halt();
    enable = 4'hF; chain = 4'h0; action = 4'b0010;
    settle();
    for (int i = 0; i < 10; i++) begin
      drive((i == 0) ? 4'b0011 : (i == 3) ? 4'b1000 : 4'b0000, 1'b0, 1'b0, i == 7, 4'h0);
      if (i == 2) begin
        n_total++; if (fire_o !== 4'b0011) $display("FAIL dbg_fire got %b want 0011", fire_o); else n_pass++;
        n_total++; if (exc_o !== 1'b0) $display("FAIL dbg_exc_prio got %b want 0", exc_o); else n_pass++;
        n_total++; if (halt_o !== 1'b0) $display("FAIL dbg_halt_early got %b want 0", halt_o); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (halt_o !== 1'b1) $display("FAIL dbg_halt_rise got %b want 1", halt_o); else n_pass++;
        n_total++; if (sticky_o !== 4'b0011) $display("FAIL dbg_sticky got %b want 0011", sticky_o); else n_pass++;
      end
      if (i == 5) begin
        n_total++; if (exc_o !== 1'b0) $display("FAIL req_exc_suppress got %b want 0", exc_o); else n_pass++;
      end
      if (i == 6) begin
        n_total++; if (sticky_o[3] !== 1'b1) $display("FAIL req_sticky3 got %b want 1", sticky_o[3]); else n_pass++;
      end
      if (i == 7) begin
        n_total++; if (halt_o !== 1'b1) $display("FAIL halt_held got %b want 1", halt_o); else n_pass++;
      end
      if (i == 8) begin
        n_total++; if (halt_o !== 1'b0) $display("FAIL halt_drop got %b want 0", halt_o); else n_pass++;
      end
      adv();
    end
    action = 4'h0;
    $display("debug_halt: request/ack handshake done");
  endtask

  task automatic test_sticky_clr();
    enable = 4'hF; chain = 4'h0; action = 4'h0;
    settle();
    for (int i = 0; i < 6; i++) begin
      drive((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0,
            (i == 2 || i == 4) ? 4'b0001 : 4'b0000);
      if (i == 3) begin
        n_total++; if (sticky_o !== 4'b0001) $display("FAIL sticky_set_wins got %b want 0001", sticky_o); else n_pass++;
      end
      if (i == 5) begin
        n_total++; if (sticky_o !== 4'b0000) $display("FAIL sticky_clear got %b want 0000", sticky_o); else n_pass++;
      end
      adv();
    end
    $display("sticky_clr: set-over-clear and clear done");
  endtask

  task automatic test_back_to_back();
    enable = 4'hF; chain = 4'h0; action = 4'h0;
    settle();
    for (int i = 0; i < 6; i++) begin
      drive((i < 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      if (i >= 2) begin
        n_total++;
        if (exc_o !== (i <= 4)) $display("FAIL b2b_exc cyc%0d got %b want %b", i, exc_o, (i <= 4));
        else n_pass++;
      end
      adv();
    end
    $display("back_to_back: consecutive exception pulses done");
  endtask

  task automatic test_reset_mid_req();
    enable = 4'hF; chain = 4'h0; action = 4'hF;
    settle();
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      adv();
    end
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
    n_total++; if (halt_o !== 1'b1) $display("FAIL rst_pre_halt got %b want 1", halt_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (halt_o !== 1'b0) $display("FAIL rst_async_halt got %b want 0", halt_o); else n_pass++;
    n_total++; if (sticky_o !== 4'b0000) $display("FAIL rst_async_sticky got %b want 0000", sticky_o); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    halt_m = 1'b0; sticky_m = 4'h0; rst_cyc = cyc; cyc++;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
      n_total++; if (halt_o !== 1'b0) $display("FAIL rst_post_idle got %b want 0", halt_o); else n_pass++;
      adv();
    end
    action = 4'h0;
    $display("reset_mid_req: async reset during request done");
  endtask

  task automatic test_random();
    settle();
    for (int b = 0; b < 6; b++) begin
      enable = 4'($urandom);
      chain  = 4'($urandom);
      action = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      for (int i = 0; i < 60; i++) begin
        drive(4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        n_total++; if (fire_o !== e_fire) $display("FAIL rnd_fire c%0d got %b want %b", cyc, fire_o, e_fire); else n_pass++;
        n_total++; if (exc_o !== e_exc) $display("FAIL rnd_exc c%0d got %b want %b", cyc, exc_o, e_exc); else n_pass++;
        n_total++; if (halt_o !== e_halt) $display("FAIL rnd_halt c%0d got %b want %b", cyc, halt_o, e_halt); else n_pass++;
        n_total++; if (sticky_o !== e_sticky) $display("FAIL rnd_sticky c%0d got %b want %b", cyc, sticky_o, e_sticky); else n_pass++;
        adv();
      end
      $display("random: block %0d en=%b ch=%b act=%b done", b, enable, chain, action);
    end
  endtask

  initial begin
    rst = 1'b1;
    match = 4'h0; chain = 4'h0; action = 4'h0; enable = 4'h0;
    clr = 4'h0; fl4 = 1'b0; fl5 = 1'b0; ack = 1'b0;
    halt_m = 1'b0; sticky_m = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single_exc();
    test_chain();
    test_flush();
    test_debug_halt();
    test_sticky_clr();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
